multi_digit_counter_display: RTL and testbench
==============================================

MULTI_DIGIT_COUNTER_DISPLAY -- requirements
Module: multi_digit_counter_display

Interface
REQ-001 SHALL have parameter DIGITS, 4, number of BCD digits counted and displayed (1..8).
REQ-002 SHALL have parameter SCAN_DIV, 50000, i_clk cycles each digit is enabled per scan slot (>=2).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a button change (>=2).
REQ-004 SHALL have port i_clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port i_rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port i_up  input  1  raw count-up button, active-low, asynchronous, bouncing.
REQ-007 SHALL have port i_down  input  1  raw count-down button, active-low, asynchronous, bouncing.
REQ-008 SHALL have port o_digitSelect  output  DIGITS  digit enables, active-low, one-cold; bit 0 = least significant digit.
REQ-009 SHALL have port o_LED  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port o_count  output  4*DIGITS  current count, packed BCD, digit 0 in [3:0].
REQ-011 SHALL have port o_wrap  output  1  one-cycle pulse on count wrap-around.

Function
REQ-012 Each button SHALL pass a 2-flop synchroniser, then a debouncer updating its debounced state only after DEBOUNCE_CYCLES consecutive equal synchronised samples differing from it.
REQ-013 A press event SHALL be a one-cycle pulse on the debounced released->pressed transition; release SHALL produce no event.
REQ-014 Counter SHALL be per-digit decimal (each nibble 0..9, ripple carry/borrow); no binary-to-BCD conversion.
REQ-015 Up event SHALL increment o_count on the edge after the pulse; from all-9s it SHALL go to 0 and assert o_wrap for that cycle.
REQ-016 Down event SHALL decrement; from 0 it SHALL go to all-9s and assert o_wrap for that cycle.
REQ-017 Up and down events in the same cycle SHALL leave o_count unchanged, o_wrap 0.
REQ-018 Scan prescaler SHALL count 0..SCAN_DIV-1; on terminal count digit index SHALL advance by 1, DIGITS-1 wrapping to 0.
REQ-019 o_digitSelect SHALL drive low only the bit of the current digit index.
REQ-020 o_LED SHALL show the current indexed digit's nibble with standard 0-9 glyphs (0 = 8'hC0, 1 = 8'hF9, 8 = 8'h80); dp always off (bit 7 = 1).
REQ-021 o_digitSelect and o_LED SHALL both derive from the same registered index so they change in the same cycle.

Reset
REQ-022 While i_rst high: o_count = 0, o_wrap = 0, digit index = 0, prescaler = 0, debounced states = released, synchronisers = released.
REQ-023 Reset outputs: o_digitSelect = all ones except bit 0 low; o_LED = 8'hC0.
REQ-024 A button held across reset deassertion SHALL register one press after DEBOUNCE_CYCLES; no event SHALL be lost or duplicated by reset mid-bounce.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN defined: digits above the most significant non-zero digit SHALL output o_LED = 8'hFF; digit 0 SHALL always display.
REQ-026 Macro undefined: every digit SHALL display its value including leading zeros.

Structure
REQ-027 Shared package seg_display_pkg SHALL hold the segment-glyph constants, blank pattern and BCD digit typedef.
REQ-028 Debouncer SHALL be sub-module button_debounce (sync + stable counter + press pulse), instantiated once per button.

Verification (bench: DIGITS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=8 unless noted)
REQ-029 Reset release -> o_count=16'h0000, o_digitSelect=4'b1110, o_LED=8'hC0, o_wrap=0.
REQ-030 i_up toggling every 3 cycles for 30 cycles then held low 20 cycles, released 20 -> exactly one increment, o_count=16'h0001.
REQ-031 DIGITS=2: 99 up presses then one more -> 8'h99 then 8'h00 with single-cycle o_wrap; one down press from 00 -> 8'h99, o_wrap pulse.
REQ-032 i_up and i_down pressed identically -> o_count unchanged, no o_wrap.
REQ-033 o_count=16'h0042: o_digitSelect cycles 1110,1101,1011,0111, each 4 cycles; with LEADING_ZERO_BLANK_EN digits 2,3 give 8'hFF, without give 8'hC0.
REQ-034 i_rst pulsed while i_up held low -> o_count=0 during reset, exactly one increment 8 cycles (+sync) after release.

Source files
------------

// File: rtl/seg_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_pkg
//  Description : Shared definitions for the multi-digit counter display.
//                BCD digit type, active-low seven-segment glyphs
//                ({dp,g,f,e,d,c,b,a}, dp always off), blank pattern and the
//                released level of the active-low push buttons.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_display_pkg;

    typedef logic [3:0] bcd_t;

    // Buttons are active-low, so the idle (released) level is high.
    localparam logic BTN_RELEASED = 1'b1;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_decode(input bcd_t digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Two-flop synchroniser, stable-sample debouncer and press
//                pulse generator for one active-low bouncing button.
//  Ports       : i_clk   - system clock
//                i_rst   - asynchronous active-high reset
//                i_btn_n - raw active-low button (asynchronous)
//                o_press - one-cycle pulse on debounced released->pressed
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
    import seg_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             press_q, press_d;

    // cnt_q holds how many consecutive synchronised samples have differed
    // from the debounced state; the DEBOUNCE_CYCLES-th such sample flips it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != state_q) begin
            if (cnt_q == CNT_MAX) begin
                state_d = sync2_q;
                press_d = (sync2_q != BTN_RELEASED);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= BTN_RELEASED;
            sync2_q <= BTN_RELEASED;
            state_q <= BTN_RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= i_btn_n;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign o_press = press_q;

endmodule
`default_nettype wire

// File: rtl/multi_digit_counter_display.sv
`default_nettype none
// ============================================================================
//  Module      : multi_digit_counter_display
//  Description : Debounced up/down BCD counter driving a multiplexed
//                active-low seven-segment display.
//  Ports       : i_clk, i_rst (async, active-high)
//                i_up, i_down      - raw active-low buttons
//                o_digitSelect     - one-cold digit enables (bit 0 = LSD)
//                o_LED             - active-low segments {dp,g,f,e,d,c,b,a}
//                o_count           - packed BCD count, digit 0 in [3:0]
//                o_wrap            - one-cycle pulse on wrap-around
//  Config      : LEADING_ZERO_BLANK_EN - blank zero digits above the most
//                significant non-zero digit (digit 0 always shown)
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_digit_counter_display
    import seg_display_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_up,
    input  logic                  i_down,
    output logic [DIGITS-1:0]     o_digitSelect,
    output logic [7:0]            o_LED,
    output logic [4*DIGITS-1:0]   o_count,
    output logic                  o_wrap
);

    localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int               PRE_W    = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic                up_press, down_press;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic                wrap_q,  wrap_d;
    logic [PRE_W-1:0]    pre_q,   pre_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic                carry;
    bcd_t                digit_val [DIGITS];
    logic [DIGITS-1:0]   blank_mask;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_debounce (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn_n (i_up),
        .o_press (up_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_debounce (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn_n (i_down),
        .o_press (down_press)
    );

    // Ripple carry/borrow across nibbles; a carry out of the top digit is
    // the wrap condition. Simultaneous up and down cancel.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b1;
        if (up_press && !down_press) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        count_d[4*i +: 4] = 4'd0;
                    end else begin
                        count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end else if (down_press && !up_press) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        count_d[4*i +: 4] = 4'd9;
                    end else begin
                        count_d[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end
    end

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign digit_val[g] = count_q[4*g +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nonzero;

    // Scan from the top digit down; a digit is blank until a non-zero digit
    // has been seen at or above it. Digit 0 is never blanked.
    always_comb begin
        blank_mask   = '0;
        seen_nonzero = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (digit_val[i] != 4'd0) begin
                seen_nonzero = 1'b1;
            end
            blank_mask[i] = ~seen_nonzero;
        end
    end
`else
    assign blank_mask = '0;
`endif

    // Select and segments both come from idx_q so they switch together.
    always_comb begin
        o_digitSelect        = '1;
        o_digitSelect[idx_q] = 1'b0;
    end

    assign o_LED   = blank_mask[idx_q] ? SEG_BLANK : seg_decode(digit_val[idx_q]);
    assign o_count = count_q;
    assign o_wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_counter_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_digit_counter_display
//  Description : Scoreboard bench. DUT A: DIGITS=4, DUT B: DIGITS=2, both
//                SCAN_DIV=4, DEBOUNCE_CYCLES=8. Stimulus pushes expected
//                count/wrap pairs; monitors pop them on every count change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_digit_counter_display;

    typedef struct packed {
        logic [15:0] cnt;
        logic        wrap;
    } exp_t;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        up_a = 1'b1, down_a = 1'b1;
    logic        up_b = 1'b1, down_b = 1'b1;
    logic [3:0]  a_sel;
    logic [7:0]  a_led;
    logic [15:0] a_count;
    logic        a_wrap;
    logic [1:0]  b_sel;
    logic [7:0]  b_led;
    logic [7:0]  b_count;
    logic        b_wrap;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   ma = 0, mb = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [15:0] prev_a = '0;
    logic [7:0]  prev_b = '0;

    always #5 clk = ~clk;

    multi_digit_counter_display #(.DIGITS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_up(up_a), .i_down(down_a),
        .o_digitSelect(a_sel), .o_LED(a_led), .o_count(a_count), .o_wrap(a_wrap)
    );

    multi_digit_counter_display #(.DIGITS(2), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_up(up_b), .i_down(down_b),
        .o_digitSelect(b_sel), .o_LED(b_led), .o_count(b_count), .o_wrap(b_wrap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_a(input bit u, input bit d);
        exp_t e;
        if (u && !d) begin
            e.wrap = (ma == 9999);
            ma = (ma + 1) % 10000;
            e.cnt = to_bcd(ma);
            qa.push_back(e);
        end else if (d && !u) begin
            e.wrap = (ma == 0);
            ma = (ma + 9999) % 10000;
            e.cnt = to_bcd(ma);
            qa.push_back(e);
        end
    endtask

    task automatic model_b(input bit u, input bit d);
        exp_t e;
        if (u && !d) begin
            e.wrap = (mb == 99);
            mb = (mb + 1) % 100;
            e.cnt = to_bcd(mb);
            qb.push_back(e);
        end else if (d && !u) begin
            e.wrap = (mb == 0);
            mb = (mb + 99) % 100;
            e.cnt = to_bcd(mb);
            qb.push_back(e);
        end
    endtask

    task automatic press_a(input bit u, input bit d);
        model_a(u, d);
        up_a   = !u;
        down_a = !d;
        cyc(14);
        up_a   = 1'b1;
        down_a = 1'b1;
        cyc(14);
    endtask

    task automatic press_b(input bit u, input bit d);
        model_b(u, d);
        up_b   = !u;
        down_b = !d;
        cyc(14);
        up_b   = 1'b1;
        down_b = 1'b1;
        cyc(14);
    endtask

    task automatic drain_a();
        int k = 0;
        while (qa.size() != 0 && k < 400) begin
            cyc(1);
            k++;
        end
        if (qa.size() != 0) begin
            check("a_drain_timeout", qa.size(), 0);
            qa.delete();
        end
    endtask

    task automatic drain_b();
        int k = 0;
        while (qb.size() != 0 && k < 400) begin
            cyc(1);
            k++;
        end
        if (qb.size() != 0) begin
            check("b_drain_timeout", qb.size(), 0);
            qb.delete();
        end
    endtask

    task automatic scan_check();
        logic [3:0] prev_sel;
        logic [3:0] es;
        logic [7:0] exp_led [4];
        bit         found = 1'b0;
        int         k = 0;
`ifdef LEADING_ZERO_BLANK_EN
        exp_led = '{8'hA4, 8'h99, 8'hFF, 8'hFF};
`else
        exp_led = '{8'hA4, 8'h99, 8'hC0, 8'hC0};
`endif
        prev_sel = a_sel;
        while (!found && k < 40) begin
            cyc(1);
            if (prev_sel == 4'b0111 && a_sel == 4'b1110) found = 1'b1;
            prev_sel = a_sel;
            k++;
        end
        if (!found) begin
            check("scan_sync_timeout", 32'(found), 32'd1);
        end else begin
            for (int s = 0; s < 16; s++) begin
                if (s > 0) cyc(1);
                es = 4'b1111;
                es[s/4] = 1'b0;
                check("scan_select", a_sel, es);
                check("scan_led", a_led, exp_led[s/4]);
            end
        end
    endtask

    // Monitors: every change of o_count must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_a = '0;
        end else begin
            if (a_count !== prev_a) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_change", a_count, prev_a);
                end else begin
                    e = qa.pop_front();
                    check("a_count", a_count, e.cnt);
                    check("a_wrap", a_wrap, e.wrap);
                end
            end else if (a_wrap !== 1'b0) begin
                check("a_spurious_wrap", a_wrap, 1'b0);
            end
            prev_a = a_count;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_b = '0;
        end else begin
            if (b_count !== prev_b) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_change", b_count, prev_b);
                end else begin
                    e = qb.pop_front();
                    check("b_count", b_count, e.cnt[7:0]);
                    check("b_wrap", b_wrap, e.wrap);
                end
            end else if (b_wrap !== 1'b0) begin
                check("b_spurious_wrap", b_wrap, 1'b0);
            end
            prev_b = b_count;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check("rst_a_count", a_count, 16'h0000);
        check("rst_a_sel",   a_sel,   4'b1110);
        check("rst_a_led",   a_led,   8'hC0);
        check("rst_a_wrap",  a_wrap,  1'b0);
        check("rst_b_count", b_count, 8'h00);
        check("rst_b_sel",   b_sel,   2'b10);
        check("rst_b_led",   b_led,   8'hC0);

        fork
            begin
                // Bouncing input: runs of 3 never reach 8 stable samples.
                model_a(1'b1, 1'b0);
                for (int i = 0; i < 5; i++) begin
                    up_a = 1'b0; cyc(3);
                    up_a = 1'b1; cyc(3);
                end
                up_a = 1'b0; cyc(20);
                up_a = 1'b1; cyc(20);
                drain_a();
                check("bounce_one_inc", a_count, 16'h0001);

                press_a(1'b1, 1'b1);
                drain_a();
                check("both_pressed", a_count, 16'h0001);

                press_a(1'b0, 1'b1);
                press_a(1'b0, 1'b1);
                drain_a();
                check("a_down_wrap", a_count, 16'h9999);
                press_a(1'b1, 1'b0);
                drain_a();
                check("a_up_wrap", a_count, 16'h0000);

                repeat (42) press_a(1'b1, 1'b0);
                drain_a();
                check("a_count_42", a_count, 16'h0042);
                scan_check();
            end
            begin
                repeat (99) press_b(1'b1, 1'b0);
                drain_b();
                check("b_count_99", b_count, 8'h99);
                press_b(1'b1, 1'b0);
                drain_b();
                check("b_wrap_to_00", b_count, 8'h00);
                press_b(1'b0, 1'b1);
                drain_b();
                check("b_down_to_99", b_count, 8'h99);
            end
        join

        // Reset with up held low: count clears, then exactly one press.
        rst  = 1'b1;
        up_a = 1'b0;
        ma   = 0;
        mb   = 0;
        cyc(3);
        check("midrst_a_count", a_count, 16'h0000);
        check("midrst_b_count", b_count, 8'h00);
        check("midrst_a_sel",   a_sel,   4'b1110);
        check("midrst_a_led",   a_led,   8'hC0);
        model_a(1'b1, 1'b0);
        rst = 1'b0;
        k = 0;
        while (a_count !== 16'h0001 && k < 30) begin
            cyc(1);
            k++;
        end
        check("rst_release_latency", 32'((k >= 10) && (k <= 12)), 32'd1);
        if (k < 20) cyc(20 - k);
        up_a = 1'b1;
        cyc(14);
        drain_a();
        check("held_across_rst", a_count, 16'h0001);
        check("held_b_unchanged", b_count, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
